xmem: RTL and testbench

Versat memory functional unit: one true dual-port RAM (ports A and B), each port driven by its own configurable address generator. Sits on the data engine's data bus. Port A is also reachable by the DMA/data interface and port B by the controller. Each port feeds one DATA_W word onto `flow_out`: memory read data, or the generated address for debug.

---
 rtl/xmem_pkg.sv | 56 +++++
 rtl/xaddrgen.sv | 101 ++++++++++
 rtl/xmem.sv | 113 +++++++++++
 tb/tb_xmem.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xmem_pkg.sv
// Shared widths, configuration field layout and helpers for the xmem memory unit
// and its address generators.
package xmem_pkg;

  localparam int DATA_W         = 32;
  localparam int MEM_ADDR_W     = 10;
  localparam int PERIOD_W       = 5;
  localparam int DATABUS_W      = 64;
  localparam int N_W            = 2;
  localparam int MEMP_CONF_BITS = 4*MEM_ADDR_W + 3*PERIOD_W + N_W + 4;
  localparam int MEM_DEPTH      = 2**MEM_ADDR_W;
  localparam int N_WORDS        = 2*DATABUS_W/DATA_W;

  // Bit offsets of each field inside one port's configuration word (LSB = 0).
  localparam int OUT_ADDR_OFF = 0;
  localparam int IN_WR_OFF    = 1;
  localparam int EXT_OFF      = 2;
  localparam int REVERSE_OFF  = 3;
  localparam int DELAY_OFF    = 4;
  localparam int INCR_OFF     = DELAY_OFF + PERIOD_W;
  localparam int SHIFT_OFF    = INCR_OFF + MEM_ADDR_W;
  localparam int START_OFF    = SHIFT_OFF + MEM_ADDR_W;
  localparam int SEL_OFF      = START_OFF + MEM_ADDR_W;
  localparam int DUTY_OFF     = SEL_OFF + N_W;
  localparam int PERIOD_OFF   = DUTY_OFF + PERIOD_W;
  localparam int ITER_OFF     = PERIOD_OFF + PERIOD_W;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] iterations;
    logic [PERIOD_W-1:0]   period;
    logic [PERIOD_W-1:0]   duty;
    logic [N_W-1:0]        sel;
    logic [MEM_ADDR_W-1:0] start;
    logic [MEM_ADDR_W-1:0] shift;
    logic [MEM_ADDR_W-1:0] incr;
    logic [PERIOD_W-1:0]   delay;
    logic                  reverse;
    logic                  ext;
    logic                  in_wr;
    logic                  out_addr;
  } memp_conf_t;

  typedef enum logic [1:0] {
    AG_IDLE,
    AG_DELAY,
    AG_RUN,
    AG_DRAIN
  } ag_state_t;

  function automatic logic [MEM_ADDR_W-1:0] bitrev(input logic [MEM_ADDR_W-1:0] a);
    logic [MEM_ADDR_W-1:0] r;
    for (int i = 0; i < MEM_ADDR_W; i++) r[i] = a[MEM_ADDR_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/xaddrgen.sv
// Configurable address generator: start delay, nested iteration/period loops,
// duty-gated step enable and a wrap-around address accumulator.
module xaddrgen
  import xmem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  run,
  input  logic [MEM_ADDR_W-1:0] iterations,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [PERIOD_W-1:0]   duty,
  input  logic [MEM_ADDR_W-1:0] start,
  input  logic [MEM_ADDR_W-1:0] shift,
  input  logic [MEM_ADDR_W-1:0] incr,
  input  logic [PERIOD_W-1:0]   delay,
  output logic [MEM_ADDR_W-1:0] addr,
  output logic                  done,
  output logic                  en
);

  ag_state_t             state, state_nxt;
  logic [MEM_ADDR_W-1:0] addr_nxt, iter_cnt, iter_cnt_nxt;
  logic [PERIOD_W-1:0]   per_cnt, per_cnt_nxt, dly_cnt, dly_cnt_nxt;
  logic                  empty, per_last, iter_last;

  assign empty     = (iterations == '0) || (period == '0);
  assign per_last  = (per_cnt + PERIOD_W'(1)) == period;
  assign iter_last = (iter_cnt + MEM_ADDR_W'(1)) == iterations;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    iter_cnt_nxt = iter_cnt;
    per_cnt_nxt  = per_cnt;
    dly_cnt_nxt  = dly_cnt;
    en           = 1'b0;
    if (init) begin
      state_nxt    = AG_IDLE;
      addr_nxt     = start;
      iter_cnt_nxt = '0;
      per_cnt_nxt  = '0;
      dly_cnt_nxt  = '0;
    end else begin
      case (state)
        AG_IDLE: begin
          if (run) begin
            iter_cnt_nxt = '0;
            per_cnt_nxt  = '0;
            dly_cnt_nxt  = '0;
            state_nxt    = (delay == '0) ? AG_RUN : AG_DELAY;
          end
        end
        AG_DELAY: begin
          dly_cnt_nxt = dly_cnt + PERIOD_W'(1);
          if (dly_cnt_nxt == delay) state_nxt = AG_RUN;
        end
        AG_RUN: begin
          if (empty) begin
            state_nxt = AG_IDLE;
          end else begin
            en = per_cnt < duty;
            if (per_last) begin
              per_cnt_nxt = '0;
              addr_nxt    = addr + incr + shift;
              if (iter_last) state_nxt = AG_DRAIN;
              else           iter_cnt_nxt = iter_cnt + MEM_ADDR_W'(1);
            end else begin
              per_cnt_nxt = per_cnt + PERIOD_W'(1);
              addr_nxt    = addr + incr;
            end
          end
        end
        // Last address is being registered onto flow_out; done follows one edge later.
        AG_DRAIN: state_nxt = AG_IDLE;
        default:  state_nxt = AG_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= AG_IDLE;
      addr     <= '0;
      iter_cnt <= '0;
      per_cnt  <= '0;
      dly_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      iter_cnt <= iter_cnt_nxt;
      per_cnt  <= per_cnt_nxt;
      dly_cnt  <= dly_cnt_nxt;
    end
  end

  assign done = (state == AG_IDLE);

endmodule

// File: rtl/xmem.sv
// Versat memory unit: true dual-port RAM, one address generator per port.
// Define XMEM_BITREV_EN to honour the per-port address bit-reversal option.
module xmem
  import xmem_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        initA,
  input  logic                        initB,
  input  logic                        runA,
  input  logic                        runB,
  output logic                        doneA,
  output logic                        doneB,
  input  logic                        ctr_mem_valid,
  input  logic                        ctr_we,
  input  logic [MEM_ADDR_W-1:0]       ctr_addr,
  input  logic [DATA_W-1:0]           ctr_data_in,
  input  logic                        data_mem_valid,
  input  logic                        data_we,
  input  logic [MEM_ADDR_W-1:0]       data_addr,
  input  logic [DATA_W-1:0]           data_data_in,
  input  logic [2*DATABUS_W-1:0]      flow_in,
  output logic [2*DATA_W-1:0]         flow_out,
  input  logic [2*MEMP_CONF_BITS-1:0] config_bits
);

  memp_conf_t                         conf_a, conf_b;
  logic [N_WORDS-1:0][DATA_W-1:0]     flow_words;
  logic [MEM_ADDR_W-1:0]              raw_a, raw_b, gen_a, gen_b, addr_a, addr_b;
  logic                               en_a, en_b, we_a, we_b;
  logic [DATA_W-1:0]                  din_a, din_b, ram_q_a, ram_q_b;
  logic [DATA_W-1:0]                  mem [MEM_DEPTH];
  logic [2*DATA_W-1:0]                flow_q;
  logic                               unused_conf;

  assign conf_a     = memp_conf_t'(config_bits[2*MEMP_CONF_BITS-1:MEMP_CONF_BITS]);
  assign conf_b     = memp_conf_t'(config_bits[MEMP_CONF_BITS-1:0]);
  assign flow_words = flow_in;

  xaddrgen u_ag_a (
    .clk        (clk),
    .rst        (rst),
    .init       (initA),
    .run        (runA),
    .iterations (conf_a.iterations),
    .period     (conf_a.period),
    .duty       (conf_a.duty),
    .start      (conf_a.start),
    .shift      (conf_a.shift),
    .incr       (conf_a.incr),
    .delay      (conf_a.delay),
    .addr       (raw_a),
    .done       (doneA),
    .en         (en_a)
  );

  xaddrgen u_ag_b (
    .clk        (clk),
    .rst        (rst),
    .init       (initB),
    .run        (runB),
    .iterations (conf_b.iterations),
    .period     (conf_b.period),
    .duty       (conf_b.duty),
    .start      (conf_b.start),
    .shift      (conf_b.shift),
    .incr       (conf_b.incr),
    .delay      (conf_b.delay),
    .addr       (raw_b),
    .done       (doneB),
    .en         (en_b)
  );

`ifdef XMEM_BITREV_EN
  assign gen_a       = conf_a.reverse ? bitrev(raw_a) : raw_a;
  assign gen_b       = conf_b.reverse ? bitrev(raw_b) : raw_b;
  assign unused_conf = conf_a.ext ^ conf_b.ext;
`else
  assign gen_a       = raw_a;
  assign gen_b       = raw_b;
  assign unused_conf = conf_a.ext ^ conf_b.ext ^ conf_a.reverse ^ conf_b.reverse;
`endif

  // External accesses (DMA on A, controller on B) override the generators.
  assign addr_a = data_mem_valid ? data_addr    : gen_a;
  assign we_a   = data_mem_valid ? data_we      : (en_a & conf_a.in_wr);
  assign din_a  = data_mem_valid ? data_data_in : flow_words[conf_a.sel];
  assign addr_b = ctr_mem_valid  ? ctr_addr     : gen_b;
  assign we_b   = ctr_mem_valid  ? ctr_we       : (en_b & conf_b.in_wr);
  assign din_b  = ctr_mem_valid  ? ctr_data_in  : flow_words[conf_b.sel];

  // NOTE: the RAM array and its read registers have no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= din_b;
    if (we_a) mem[addr_a] <= din_a;  // later assignment wins: port A on a collision
    ram_q_a <= mem[addr_a];
    ram_q_b <= mem[addr_b];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flow_q <= '0;
    end else begin
      flow_q[2*DATA_W-1:DATA_W] <= conf_a.out_addr ?
                                   {{(DATA_W-MEM_ADDR_W){1'b0}}, gen_a} : ram_q_a;
      flow_q[DATA_W-1:0]        <= conf_b.out_addr ?
                                   {{(DATA_W-MEM_ADDR_W){1'b0}}, gen_b} : ram_q_b;
    end
  end

  assign flow_out = flow_q;

endmodule

// File: tb/tb_xmem.sv
// Directed bench for xmem: table-driven port accesses plus hand-written
// address-generator sequences (delay, duty, writes, reset, abort, bit reversal).
module tb_xmem;

  localparam int CB = 4*10 + 3*5 + 2 + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          initA, initB, runA, runB, doneA, doneB;
  logic          ctr_mem_valid, ctr_we, data_mem_valid, data_we;
  logic [9:0]    ctr_addr, data_addr;
  logic [31:0]   ctr_data_in, data_data_in;
  logic [127:0]  flow_in;
  logic [63:0]   flow_out;
  logic [2*CB-1:0] config_bits;

  int n_vec = 0;
  int n_err = 0;

  xmem dut (
    .clk            (clk),
    .rst            (rst),
    .initA          (initA),
    .initB          (initB),
    .runA           (runA),
    .runB           (runB),
    .doneA          (doneA),
    .doneB          (doneB),
    .ctr_mem_valid  (ctr_mem_valid),
    .ctr_we         (ctr_we),
    .ctr_addr       (ctr_addr),
    .ctr_data_in    (ctr_data_in),
    .data_mem_valid (data_mem_valid),
    .data_we        (data_we),
    .data_addr      (data_addr),
    .data_data_in   (data_data_in),
    .flow_in        (flow_in),
    .flow_out       (flow_out),
    .config_bits    (config_bits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv, dwe;
    logic [9:0]  da;
    logic [31:0] dd;
    logic        cv, cwe;
    logic [9:0]  ca;
    logic [31:0] cd;
    logic        chk;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [11];
  int   exp_a [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fields in MSB-first order; ext is always driven 0.
  function automatic logic [CB-1:0] conf(input int iter, input int period, input int duty,
                                         input int sel, input int start, input int shift,
                                         input int incr, input int delay, input int reverse,
                                         input int in_wr, input int out_addr);
    logic [9:0] it, st, sh, ic;
    logic [4:0] pe, du, de;
    logic [1:0] se;
    it = iter[9:0];  pe = period[4:0]; du = duty[4:0]; se = sel[1:0];
    st = start[9:0]; sh = shift[9:0];  ic = incr[9:0]; de = delay[4:0];
    return {it, pe, du, se, st, sh, ic, de, reverse[0], 1'b0, in_wr[0], out_addr[0]};
  endfunction

  task automatic pulse_init_a();
    initA = 1'b1; tick(); initA = 1'b0;
  endtask

  task automatic write_a(input logic [9:0] a, input logic [31:0] d);
    data_mem_valid = 1'b1; data_we = 1'b1; data_addr = a; data_data_in = d;
    tick();
    data_mem_valid = 1'b0; data_we = 1'b0;
  endtask

  task automatic read_a(input logic [9:0] a, input logic [31:0] exp, input string name);
    data_mem_valid = 1'b1; data_we = 1'b0; data_addr = a;
    tick();
    data_mem_valid = 1'b0;
    tick();
    check(name, {32'h0, flow_out[63:32]}, {32'h0, exp});
  endtask

  // Reference sequence: iterations 3, period/duty 3, start 0, shift 2, incr 1.
  task automatic run_seq_a(input string tag);
    config_bits = {conf(3, 3, 3, 0, 0, 2, 1, 0, 0, 0, 1), {CB{1'b0}}};
    pulse_init_a();
    runA = 1'b1; tick(); runA = 1'b0;
    check({tag, "_done_low_at_run"}, {63'h0, doneA}, 64'h0);
    for (int i = 0; i < 9; i++) begin
      if (i == 3) runA = 1'b1;  // run while running must be ignored
      tick();
      runA = 1'b0;
      check($sformatf("%s_addr%0d", tag, i), {32'h0, flow_out[63:32]}, 64'(exp_a[i]));
      check($sformatf("%s_busy%0d", tag, i), {63'h0, doneA}, 64'h0);
    end
    tick();
    check({tag, "_done_high"}, {63'h0, doneA}, 64'h1);
  endtask

  initial begin
    rst = 1'b0;
    initA = 0; initB = 0; runA = 0; runB = 0;
    ctr_mem_valid = 0; ctr_we = 0; ctr_addr = '0; ctr_data_in = '0;
    data_mem_valid = 0; data_we = 0; data_addr = '0; data_data_in = '0;
    flow_in = '0;
    config_bits = '0;

    tbl[0]  = '{1'b1, 1'b1, 10'd16,  32'h6789ABCD, 1'b1, 1'b1, 10'd10,  32'hF0F0F0F0, 1'b0, 64'h0};
    tbl[1]  = '{1'b1, 1'b0, 10'd16,  32'h0,        1'b1, 1'b0, 10'd10,  32'h0,        1'b0, 64'h0};
    tbl[2]  = '{1'b0, 1'b0, 10'd0,   32'h0,        1'b0, 1'b0, 10'd0,   32'h0,        1'b1, 64'h6789ABCD_F0F0F0F0};
    tbl[3]  = '{1'b1, 1'b1, 10'd20,  32'h11111111, 1'b1, 1'b1, 10'd20,  32'h22222222, 1'b0, 64'h0};
    tbl[4]  = '{1'b1, 1'b0, 10'd20,  32'h0,        1'b1, 1'b0, 10'd20,  32'h0,        1'b0, 64'h0};
    tbl[5]  = '{1'b0, 1'b0, 10'd0,   32'h0,        1'b0, 1'b0, 10'd0,   32'h0,        1'b1, 64'h11111111_11111111};
    tbl[6]  = '{1'b1, 1'b1, 10'h3FF, 32'hAAAA5555, 1'b1, 1'b1, 10'd0,   32'h0000FFFF, 1'b0, 64'h0};
    tbl[7]  = '{1'b1, 1'b0, 10'd0,   32'h0,        1'b1, 1'b0, 10'h3FF, 32'h0,        1'b0, 64'h0};
    tbl[8]  = '{1'b0, 1'b0, 10'd0,   32'h0,        1'b0, 1'b0, 10'd0,   32'h0,        1'b1, 64'h0000FFFF_AAAA5555};
    tbl[9]  = '{1'b1, 1'b0, 10'd10,  32'h0,        1'b1, 1'b0, 10'd16,  32'h0,        1'b0, 64'h0};
    tbl[10] = '{1'b0, 1'b0, 10'd0,   32'h0,        1'b0, 1'b0, 10'd0,   32'h0,        1'b1, 64'hF0F0F0F0_6789ABCD};

    #12;
    check("reset_flow_out", flow_out, 64'h0);
    check("reset_done", {62'h0, doneA, doneB}, 64'h3);
    rst = 1'b1;
    tick();

    // Port accesses from the table; read data lands two edges after the address.
    for (int i = 0; i < 11; i++) begin
      data_mem_valid = tbl[i].dv; data_we = tbl[i].dwe; data_addr = tbl[i].da; data_data_in = tbl[i].dd;
      ctr_mem_valid  = tbl[i].cv; ctr_we  = tbl[i].cwe; ctr_addr  = tbl[i].ca; ctr_data_in  = tbl[i].cd;
      tick();
      check($sformatf("vec%0d_done", i), {62'h0, doneA, doneB}, 64'h3);
      if (tbl[i].chk) check($sformatf("vec%0d_flow", i), flow_out, tbl[i].exp);
    end
    data_mem_valid = 0; data_we = 0; ctr_mem_valid = 0; ctr_we = 0;

    run_seq_a("seqA");

    // Port B generator: start 8, incr 2, period 4.
    config_bits = {{CB{1'b0}}, conf(1, 4, 4, 0, 8, 0, 2, 0, 0, 0, 1)};
    initB = 1'b1; tick(); initB = 1'b0;
    runB = 1'b1; tick(); runB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("genB_addr%0d", i), {32'h0, flow_out[31:0]}, 64'(8 + 2*i));
    end
    tick();
    check("genB_done", {63'h0, doneB}, 64'h1);

    // Zero iterations: done drops for one cycle, no addresses.
    config_bits = {conf(0, 3, 3, 0, 0, 0, 1, 0, 0, 0, 1), {CB{1'b0}}};
    pulse_init_a();
    runA = 1'b1; tick(); runA = 1'b0;
    check("empty_done_low", {63'h0, doneA}, 64'h0);
    tick();
    check("empty_done_high", {63'h0, doneA}, 64'h1);

    // Delay 4 with flow writes of word 1 to addresses 0..2.
    flow_in = {32'h33, 32'h22, 32'h55, 32'h11};
    config_bits = {conf(1, 3, 3, 1, 0, 0, 1, 4, 0, 1, 1), {CB{1'b0}}};
    pulse_init_a();
    runA = 1'b1; tick(); runA = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      check($sformatf("delay_addr_t%0d", t), {32'h0, flow_out[63:32]}, 64'((t <= 5) ? 0 : t - 5));
      check($sformatf("delay_busy_t%0d", t), {63'h0, doneA}, 64'h0);
    end
    tick();
    check("delay_done", {63'h0, doneA}, 64'h1);
    config_bits = '0;
    for (int i = 0; i < 3; i++) read_a(10'(i), 32'h55, $sformatf("wr_sel1_ram%0d", i));

    // Duty 2 of period 3: only steps 0 and 1 write flow word 2.
    for (int i = 0; i < 6; i++) write_a(10'(32 + i), 32'hDEAD0000 + 32'(i));
    config_bits = {conf(2, 3, 2, 2, 32, 0, 1, 0, 0, 1, 0), {CB{1'b0}}};
    pulse_init_a();
    runA = 1'b1; tick(); runA = 1'b0;
    begin
      int budget;
      budget = 0;
      while (!doneA && budget < 50) begin
        tick();
        budget++;
      end
      check("duty_done_in_budget", {63'h0, doneA}, 64'h1);
    end
    read_a(10'd32, 32'h22,       "duty_ram32");
    read_a(10'd33, 32'h22,       "duty_ram33");
    read_a(10'd34, 32'hDEAD0002, "duty_ram34");
    read_a(10'd35, 32'h22,       "duty_ram35");
    read_a(10'd36, 32'h22,       "duty_ram36");
    read_a(10'd37, 32'hDEAD0005, "duty_ram37");

    // Init while running aborts and reloads start.
    config_bits = {conf(3, 3, 3, 0, 0, 2, 1, 0, 0, 0, 1), {CB{1'b0}}};
    pulse_init_a();
    runA = 1'b1; tick(); runA = 1'b0;
    tick(); tick(); tick();
    pulse_init_a();
    check("abort_done", {63'h0, doneA}, 64'h1);
    tick();
    check("abort_start", {32'h0, flow_out[63:32]}, 64'h0);

    // Asynchronous reset in the middle of a sequence, then a full rerun.
    pulse_init_a();
    runA = 1'b1; tick(); runA = 1'b0;
    tick(); tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_flow", flow_out, 64'h0);
    check("midrst_done", {62'h0, doneA, doneB}, 64'h3);
    #1 rst = 1'b1;
    run_seq_a("rerun");

    // Bit reversal of generated address 1.
    config_bits = {conf(1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1), {CB{1'b0}}};
    pulse_init_a();
    tick();
`ifdef XMEM_BITREV_EN
    check("bitrev_addr", {32'h0, flow_out[63:32]}, 64'd512);
`else
    check("bitrev_ignored", {32'h0, flow_out[63:32]}, 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
